chunk_serial_adder: RTL and testbench
=====================================

CHUNK_SERIAL_ADDER -- requirements
Module: chunk_serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 4, meaning bits added per clock cycle; legal only when CHUNK >= 1 and WIDTH % CHUNK == 0; N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  request to begin an operation.
REQ-006 The block SHALL have port mode  input  1  operation select: 0 = add, 1 = subtract.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 The block SHALL have port busy  output  1  operation in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle result-valid strobe.
REQ-012 The block SHALL have port sum  output  WIDTH  result.
REQ-013 The block SHALL have port cout  output  1  carry-out (subtract: 1 = no borrow).
REQ-014 The block SHALL have port ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DONE.
REQ-016 On a rising edge in IDLE or DONE with start=1, the block SHALL latch a, mode, cin, and b_eff (b when mode=0, ~b when mode=1), set carry = cin (mode=0) or ~cin (mode=1), clear the chunk index, and enter RUN.
REQ-017 mode=0 SHALL compute a + b + cin; mode=1 SHALL compute a - b - cin, implemented as a + ~b + ~cin.
REQ-018 Each RUN cycle SHALL add chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) of a and b_eff plus carry into an internal shadow register, LSB chunk first, and update carry with the chunk's carry-out.
REQ-019 After chunk N-1, the block SHALL copy the shadow register to sum, set cout to the final carry, set ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), and enter DONE.
REQ-020 done SHALL be 1 only in DONE, exactly N rising edges after the edge that sampled start; DONE SHALL last one cycle, then return to IDLE if start=0.
REQ-021 busy SHALL be 1 exactly while in RUN.
REQ-022 start SHALL be ignored while in RUN; operand changes during RUN SHALL not affect the result.
REQ-023 start=1 in DONE SHALL begin a new operation on that edge (back-to-back, no idle cycle).
REQ-024 sum, cout, and ovf SHALL change only on the transition into DONE and SHALL hold their values otherwise, including during RUN.
REQ-025 For CHUNK == WIDTH (N=1), the whole addition SHALL complete in the single RUN cycle.
REQ-026 All arithmetic SHALL be unsigned modulo 2^WIDTH; the carry out of bit WIDTH-1 SHALL go to cout only.

Reset
REQ-027 While rst_n=0, regardless of clk, state SHALL be IDLE and busy, done, sum, cout, ovf, carry, chunk index, and shadow register SHALL be 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave per REQ-016.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-029 a=0x0001, b=0x0002, cin=0, mode=0, start for 1 cycle -> busy for 4 cycles, done on the 4th edge after start, sum=0x0003, cout=0, ovf=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0, mode=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-031 mode=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; mode=1, a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
REQ-032 start re-pulsed and a/b changed during RUN -> ignored; result matches the originally latched operands; sum holds the prior result until done.
REQ-033 rst_n pulled low during the 2nd RUN cycle -> busy, done, sum, cout, ovf go to 0 immediately; no done pulse; the next operation 0x1234+0x1111 gives 0x2345.
REQ-034 Parameters WIDTH=16, CHUNK=16; start held high continuously with new operands every DONE cycle -> done on every 2nd edge, each result correct, no idle cycle between operations.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Serial adder/subtractor: processes CHUNK bits per clock, LSB chunk first,
// and publishes sum/cout/ovf only when the last chunk has been added.
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state_o
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshake: start is sampled on any rising edge outside RUN; done is a
  // one-cycle strobe and sum/cout/ovf stay valid until the next completion.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] shadow_next;
  logic             accept, last_chunk;

  assign accept     = start && (state_q != S_RUN);
  assign last_chunk = (idx_q == IDXW'(N - 1));

  // Operands shift right so the active chunk always sits at bit 0; the
  // result shifts in from the top so it is aligned after N steps.
  assign chunk_res   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, carry_q};
  assign shadow_next = (shadow_q >> CHUNK)
                     | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_chunk) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    idx_d    = idx_q;
    if (accept) begin
      // Subtract is a + ~b + ~cin: borrow-in inverts into carry-in.
      a_d     = a;
      b_d     = mode ? ~b : b;
      carry_d = mode ? ~cin : cin;
      a_msb_d = a[WIDTH-1];
      b_msb_d = mode ? ~b[WIDTH-1] : b[WIDTH-1];
      idx_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d      = a_q >> CHUNK;
      b_d      = b_q >> CHUNK;
      carry_d  = chunk_res[CHUNK];
      shadow_d = shadow_next;
      idx_d    = idx_q + IDXW'(1);
      if (last_chunk) begin
        sum_d  = shadow_next;
        cout_d = chunk_res[CHUNK];
        ovf_d  = (a_msb_q == b_msb_q) && (shadow_next[WIDTH-1] != a_msb_q);
      end
    end
  end

  always_comb begin
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    sum         = sum_q;
    cout        = cout_q;
    ovf         = ovf_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Bench for chunk_serial_adder: a CHUNK=4 instance for functional/reset cases
// and a CHUNK=16 instance for back-to-back streaming.
module tb_chunk_serial_adder;

  localparam int W  = 16;
  localparam int NA = 4;
  localparam int NB = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         start_a, mode_a, cin_a, busy_a, done_a, cout_a, ovf_a;
  logic [W-1:0] a_a, b_a, sum_a;
  logic [1:0]   dbg_a;
  logic         start_b, mode_b, cin_b, busy_b, done_b, cout_b, ovf_b;
  logic [W-1:0] a_b, b_b, sum_b;
  logic [1:0]   dbg_b;

  chunk_serial_adder #(.WIDTH(W), .CHUNK(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .a(a_a), .b(b_a),
    .cin(cin_a), .busy(busy_a), .done(done_a), .sum(sum_a), .cout(cout_a),
    .ovf(ovf_a), .dbg_state_o(dbg_a));

  chunk_serial_adder #(.WIDTH(W), .CHUNK(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .a(a_b), .b(b_b),
    .cin(cin_b), .busy(busy_b), .done(done_b), .sum(sum_b), .cout(cout_b),
    .ovf(ovf_b), .dbg_state_o(dbg_b));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_a_q[$];
  logic [W+1:0] exp_b_q[$];
  int           due_a_q[$];
  int           due_b_q[$];
  logic [W-1:0] last_sum_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic mode);
    longint ua, ub, sa, sb, u, s;
    logic [63:0] u_bits;
    logic co, ov;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (!mode) begin
      u  = ua + ub + longint'(cin);
      s  = sa + sb + longint'(cin);
      co = (u >= (longint'(1) << W));
    end else begin
      u  = ua - ub - longint'(cin);
      s  = sa - sb - longint'(cin);
      co = (u >= 0);
    end
    ov = (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
    u_bits = u;
    return {u_bits[W-1:0], co, ov};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_a: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        check("result_a", {46'd0, sum_a, cout_a, ovf_a}, {46'd0, exp_a_q.pop_front()});
        check("latency_a", 64'(cyc), 64'(due_a_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done_b) begin
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_b: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        check("result_b", {46'd0, sum_b, cout_b, ovf_b}, {46'd0, exp_b_q.pop_front()});
        check("latency_b", 64'(cyc), 64'(due_b_q.pop_front()));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic issue_a(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic mode, input bit disturb);
    logic [W+1:0] e;
    int nb;
    @(negedge clk);
    a_a = a; b_a = b; cin_a = cin; mode_a = mode; start_a = 1'b1;
    e = ref_model(a, b, cin, mode);
    exp_a_q.push_back(e);
    due_a_q.push_back(cyc + 1 + NA);
    @(negedge clk);
    start_a = 1'b0;
    a_a = W'($urandom); b_a = W'($urandom);
    nb = 0;
    for (int i = 0; i < 20 && !done_a; i++) begin
      if (busy_a) nb++;
      check("sum_hold_a", 64'(sum_a), 64'(last_sum_a));
      start_a = (disturb && nb == 1);
      if (disturb) begin
        a_a = W'($urandom); b_a = W'($urandom); cin_a = 1'($urandom);
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    if (!done_a) begin
      checks++; errors++;
      $display("FAIL timeout_a: got no done expected done within 20 cycles");
    end
    check("busy_cycles_a", 64'(nb), 64'(NA));
    last_sum_a = e[W+1:2];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W+1:0] e;
    rst_n = 1'b0;
    start_a = 0; mode_a = 0; cin_a = 0; a_a = '0; b_a = '0;
    start_b = 0; mode_b = 0; cin_b = 0; a_b = '0; b_b = '0;
    last_sum_a = '0;
    repeat (3) @(negedge clk);
    check("reset_busy_a", 64'(busy_a), 64'd0);
    check("reset_done_a", 64'(done_a), 64'd0);
    check("reset_outs_a", {46'd0, sum_a, cout_a, ovf_a}, 64'd0);
    check("reset_state_a", 64'(dbg_a), 64'd0);
    check("reset_outs_b", {45'd0, sum_b, cout_b, ovf_b, busy_b}, 64'd0);
    rst_n = 1'b1;

    issue_a(16'h0001, 16'h0002, 1'b0, 1'b0, 0);
    issue_a(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    issue_a(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    issue_a(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    issue_a(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    issue_a(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1);
    issue_a(16'h1000, 16'h2000, 1'b1, 1'b1, 1);
    for (int k = 0; k < 30; k++)
      issue_a(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));

    // Abort in the 2nd RUN cycle.
    issue_a(16'h0F0F, 16'h0101, 1'b0, 1'b0, 0);
    @(negedge clk);
    a_a = 16'h4444; b_a = 16'h1111; cin_a = 0; mode_a = 0; start_a = 1'b1;
    exp_a_q.push_back(ref_model(16'h4444, 16'h1111, 1'b0, 1'b0));
    due_a_q.push_back(cyc + 1 + NA);
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 64'(busy_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_done", 64'(done_a), 64'd0);
    check("abort_outs", {46'd0, sum_a, cout_a, ovf_a}, 64'd0);
    void'(exp_a_q.pop_back());
    void'(due_a_q.pop_back());
    last_sum_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", 64'(done_a), 64'd0);
    end
    issue_a(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    check("post_reset_sum", 64'(sum_a), 64'h2345);

    // Back-to-back streaming on the single-chunk instance.
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      a_b = (k == 0) ? 16'h7FFF : W'($urandom);
      b_b = (k == 0) ? 16'h0001 : W'($urandom);
      cin_b = (k == 0) ? 1'b0 : 1'($urandom);
      mode_b = (k == 0) ? 1'b0 : 1'($urandom);
      start_b = 1'b1;
      exp_b_q.push_back(ref_model(a_b, b_b, cin_b, mode_b));
      due_b_q.push_back(cyc + 1 + NB);
      @(negedge clk);
      check("stream_busy_b", 64'(busy_b), 64'd1);
      @(negedge clk);
    end
    start_b = 1'b0;
    repeat (4) @(negedge clk);

    check("drain_a", 64'(exp_a_q.size()), 64'd0);
    check("drain_b", 64'(exp_b_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
